sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
- SAP-1 control/sequencing unit: 6-state one-hot ring counter (T1..T6) plus instruction decoder.
- Drives the 12-bit control word that steers the program counter, memory address register, RAM, instruction register, accumulator, adder/subtractor, B register and output register.
- Sits between the instruction register (4-bit opcode input) and all datapath enables on the shared 8-bit W bus.
- Also detects HLT and freezes the machine.

Parameters:
- None. Widths are fixed by the SAP-1 architecture.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-low; reset==0 clears sequencer
- instruction  input  4  opcode nibble from instruction register; must be stable from T4 to T6
- control_word  output  12  {Cp, Ep, Lm_n, Ce_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}, MSB first; *_n bits active-low
- t_state  output  6  one-hot ring state, bit0=T1 … bit5=T6
- halted  output  1  high once HLT decoded; held until reset

Behaviour:
- Reset (reset==0, asynchronous): t_state=000001 (T1), halted=0, control_word=5E3h immediately.
- Ring counter: advances one state per rising clock edge, T1→T2→…→T6→T1. Not halted ⇒ advances every cycle, no stalls.
- control_word is purely combinational from t_state, latched halt flag and instruction. No extra register stage; zero latency relative to state.
- Fetch (all opcodes):
  - T1 = 5E3h (Ep, Lm_n=0)
  - T2 = BE3h (Cp)
  - T3 = 263h (Ce_n=0, Li_n=0)
- Opcodes: LDA=0h, ADD=1h, SUB=2h, OUT=Eh, HLT=Fh.
- Execute words T4/T5/T6:
  - LDA: 1A3h / 2C3h / 3E3h
  - ADD: 1A3h / 2E1h / 3C7h
  - SUB: 1A3h / 2E1h / 3CFh
  - OUT: 3F2h / 3E3h / 3E3h
  - Any other opcode (3h–Dh): NOP, 3E3h in T4–T6
- NOP word 3E3h: no bus driver enabled, no load active.
- HLT: on the rising edge leaving T4 with instruction==Fh, set halted=1.
  - T4 of HLT itself outputs 3E3h.
  - Once halted: t_state frozen at current value, control_word forced to 3E3h every cycle regardless of instruction.
  - Only reset clears halted.
- Instruction is sampled combinationally only during T4–T6. Changes during T1–T3 have no effect on outputs.
- Reset mid-instruction (any T state, halted or not): immediate return to T1 / 5E3h. The next clock edge after reset release goes to T2.
- Illegal t_state (not one-hot, e.g. from an upset): next edge forces T1. control_word = 3E3h while illegal.
- Bus exclusivity invariant: at most one of Ep, ~Ce_n, ~Ei_n, Ea, Eu active in any state.

Decomposition:
- Package sap_pkg:
  - opcode enum (LDA, ADD, SUB, OUT, HLT)
  - 12-bit control-word localparams (CW_T1, CW_T2, CW_T3, CW_NOP, CW_LDA_T4…, CW_SUB_T6)
  - bit-index constants for each control field
- Sub-module sap_ring_counter: 6-bit one-hot counter with async active-low reset, hold input, illegal-state recovery.
- Decoder stays in the top block as a case on (t_state, instruction).

Test Plan:
- Reset low mid-T5 → control_word=5E3h and t_state=000001 immediately. After release, successive edges give BE3h, 263h.
- instruction=1h (ADD) through one cycle → sequence 5E3h, BE3h, 263h, 1A3h, 2E1h, 3C7h, then back to 5E3h.
- instruction=2h (SUB) → T6 word 3CFh. instruction=0h (LDA) → T5 word 2C3h, T6 3E3h.
- instruction=Eh (OUT) → T4=3F2h, T5=T6=3E3h. instruction=7h → T4–T6 all 3E3h.
- instruction=Fh → halted=1 after the T4 edge. t_state and control_word=3E3h hold for 20+ clocks even if instruction changes. reset=0 clears halted and restores T1.
- Toggle instruction randomly during T1–T3 → fetch words unchanged. Every cycle, assert at most one bus driver active.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: shared opcodes, ring states and control-word constants for the SAP-1 sequencer
package sap_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // bit positions inside control_word {Cp, Ep, Lm_n, Ce_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n}
    localparam int CP   = 11;
    localparam int EP   = 10;
    localparam int LM_N = 9;
    localparam int CE_N = 8;
    localparam int LI_N = 7;
    localparam int EI_N = 6;
    localparam int LA_N = 5;
    localparam int EA   = 4;
    localparam int SU   = 3;
    localparam int EU   = 2;
    localparam int LB_N = 1;
    localparam int LO_N = 0;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [11:0] CW_T1     = 12'h5E3;
    localparam logic [11:0] CW_T2     = 12'hBE3;
    localparam logic [11:0] CW_T3     = 12'h263;
    localparam logic [11:0] CW_NOP    = 12'h3E3;
    localparam logic [11:0] CW_LDA_T4 = 12'h1A3;
    localparam logic [11:0] CW_LDA_T5 = 12'h2C3;
    localparam logic [11:0] CW_LDA_T6 = 12'h3E3;
    localparam logic [11:0] CW_ADD_T4 = 12'h1A3;
    localparam logic [11:0] CW_ADD_T5 = 12'h2E1;
    localparam logic [11:0] CW_ADD_T6 = 12'h3C7;
    localparam logic [11:0] CW_SUB_T4 = 12'h1A3;
    localparam logic [11:0] CW_SUB_T5 = 12'h2E1;
    localparam logic [11:0] CW_SUB_T6 = 12'h3CF;
    localparam logic [11:0] CW_OUT_T4 = 12'h3F2;
    localparam logic [11:0] CW_OUT_T5 = 12'h3E3;
    localparam logic [11:0] CW_OUT_T6 = 12'h3E3;

endpackage

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: 6-state one-hot T-state ring with hold and illegal-state recovery
//   clock   in  rising-edge clock
//   reset   in  async active-low, forces T1
//   hold    in  freeze current state (halt)
//   t_state out one-hot state, bit0=T1
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       hold,
    output logic [5:0] t_state
);

    logic legal;

    // exactly one bit set; anything else re-enters the ring at T1 even while held
    assign legal = (t_state != 6'd0) && ((t_state & (t_state - 6'd1)) == 6'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            t_state <= T1;
        else if (!legal)
            t_state <= T1;
        else if (!hold)
            t_state <= {t_state[4:0], t_state[5]};
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: SAP-1 T-state sequencer and instruction decoder driving the control word
//   clock        in  rising-edge clock
//   reset        in  async active-low, returns to T1 and clears halt
//   instruction  in  opcode from IR, used during T4..T6 only
//   control_word out {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//   t_state      out one-hot ring state
//   halted       out set after HLT leaves T4, held until reset
module sap_control_sequencer
    import sap_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  instruction,
    output logic [11:0] control_word,
    output logic [5:0]  t_state,
    output logic        halted
);

    sap_ring_counter u_ring (
        .clock   (clock),
        .reset   (reset),
        .hold    (halted),
        .t_state (t_state)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            halted <= 1'b0;
        else if (t_state == T4 && instruction == OP_HLT)
            halted <= 1'b1;
    end

    // NOP is the default so halted, illegal states and unknown opcodes all idle the datapath
    always_comb begin
        control_word = CW_NOP;
        if (!halted) begin
            case (t_state)
                T1: control_word = CW_T1;
                T2: control_word = CW_T2;
                T3: control_word = CW_T3;
                T4: case (instruction)
                    OP_LDA:  control_word = CW_LDA_T4;
                    OP_ADD:  control_word = CW_ADD_T4;
                    OP_SUB:  control_word = CW_SUB_T4;
                    OP_OUT:  control_word = CW_OUT_T4;
                    default: control_word = CW_NOP;
                endcase
                T5: case (instruction)
                    OP_LDA:  control_word = CW_LDA_T5;
                    OP_ADD:  control_word = CW_ADD_T5;
                    OP_SUB:  control_word = CW_SUB_T5;
                    OP_OUT:  control_word = CW_OUT_T5;
                    default: control_word = CW_NOP;
                endcase
                T6: case (instruction)
                    OP_LDA:  control_word = CW_LDA_T6;
                    OP_ADD:  control_word = CW_ADD_T6;
                    OP_SUB:  control_word = CW_SUB_T6;
                    OP_OUT:  control_word = CW_OUT_T6;
                    default: control_word = CW_NOP;
                endcase
                default: control_word = CW_NOP;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb_sap_control_sequencer: directed scoreboard bench for the SAP-1 control sequencer
module tb_sap_control_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  instruction;
    logic [11:0] control_word;
    logic [5:0]  t_state;
    logic        halted;

    int errors = 0;
    int checks = 0;
    logic [18:0] sb[$];

    sap_control_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .instruction  (instruction),
        .control_word (control_word),
        .t_state      (t_state),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic h, input logic [11:0] cw, input logic [5:0] ts);
        logic [18:0] e;
        int drv;
        sb.push_back({h, cw, ts});
        #1;
        e = sb.pop_front();
        checks++;
        assert (control_word === e[17:6]) else begin
            errors++;
            $error("FAIL %s control_word got %h expected %h", tag, control_word, e[17:6]);
        end
        checks++;
        assert (t_state === e[5:0]) else begin
            errors++;
            $error("FAIL %s t_state got %b expected %b", tag, t_state, e[5:0]);
        end
        checks++;
        assert (halted === e[18]) else begin
            errors++;
            $error("FAIL %s halted got %b expected %b", tag, halted, e[18]);
        end
        drv = int'(control_word[10]) + int'(!control_word[8]) + int'(!control_word[6])
            + int'(control_word[4]) + int'(control_word[2]);
        checks++;
        assert (drv <= 1) else begin
            errors++;
            $error("FAIL %s bus_drivers got %0d expected <=1", tag, drv);
        end
    endtask

    // one full instruction from T1 back to T1, scrambling the opcode during fetch
    task automatic run_instr(input logic [3:0] op, input logic [11:0] e4, input logic [11:0] e5,
                             input logic [11:0] e6);
        instruction = 4'($urandom);
        chk("fetch_t1", 1'b0, 12'h5E3, 6'b000001);
        adv();
        instruction = 4'($urandom);
        chk("fetch_t2", 1'b0, 12'hBE3, 6'b000010);
        adv();
        instruction = 4'($urandom);
        chk("fetch_t3", 1'b0, 12'h263, 6'b000100);
        instruction = op;
        adv();
        chk("exec_t4", 1'b0, e4, 6'b001000);
        adv();
        chk("exec_t5", 1'b0, e5, 6'b010000);
        adv();
        chk("exec_t6", 1'b0, e6, 6'b100000);
        adv();
    endtask

    initial begin
        reset = 1'b0;
        instruction = 4'h0;
        adv();
        chk("reset_state", 1'b0, 12'h5E3, 6'b000001);
        adv();
        chk("reset_hold", 1'b0, 12'h5E3, 6'b000001);
        reset = 1'b1;
        adv();
        chk("release_t2", 1'b0, 12'hBE3, 6'b000010);
        adv();
        chk("release_t3", 1'b0, 12'h263, 6'b000100);
        instruction = 4'h0;
        adv();
        adv();
        adv();
        adv();
        run_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
        run_instr(4'h2, 12'h1A3, 12'h2E1, 12'h3CF);
        run_instr(4'h0, 12'h1A3, 12'h2C3, 12'h3E3);
        run_instr(4'hE, 12'h3F2, 12'h3E3, 12'h3E3);
        run_instr(4'h7, 12'h3E3, 12'h3E3, 12'h3E3);
        run_instr(4'h3, 12'h3E3, 12'h3E3, 12'h3E3);
        run_instr(4'hD, 12'h3E3, 12'h3E3, 12'h3E3);
        chk("wrap_t1", 1'b0, 12'h5E3, 6'b000001);
        instruction = 4'h1;
        adv();
        adv();
        adv();
        adv();
        chk("mid_t5", 1'b0, 12'h2E1, 6'b010000);
        reset = 1'b0;
        chk("async_reset_t5", 1'b0, 12'h5E3, 6'b000001);
        adv();
        reset = 1'b1;
        chk("after_release_t1", 1'b0, 12'h5E3, 6'b000001);
        adv();
        chk("after_release_t2", 1'b0, 12'hBE3, 6'b000010);
        adv();
        chk("after_release_t3", 1'b0, 12'h263, 6'b000100);
        adv();
        adv();
        adv();
        adv();
        instruction = 4'hF;
        chk("hlt_t1", 1'b0, 12'h5E3, 6'b000001);
        adv();
        adv();
        adv();
        chk("hlt_t4", 1'b0, 12'h3E3, 6'b001000);
        adv();
        chk("halted_t5", 1'b1, 12'h3E3, 6'b010000);
        for (int i = 0; i < 22; i++) begin
            instruction = 4'($urandom);
            adv();
            chk("halted_hold", 1'b1, 12'h3E3, 6'b010000);
        end
        reset = 1'b0;
        chk("halt_reset", 1'b0, 12'h5E3, 6'b000001);
        adv();
        reset = 1'b1;
        adv();
        chk("halt_release_t2", 1'b0, 12'hBE3, 6'b000010);
        adv();
        instruction = 4'h2;
        adv();
        adv();
        adv();
        adv();
        run_instr(4'h1, 12'h1A3, 12'h2E1, 12'h3C7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
